// File: rtl/io_cmd_master.sv
// Initiator side of the 24-bit {op, data} IO command interface: issues one CPU command
// as a start pulse, waits for an optional reply with timeout, and hands the result back.
module io_cmd_master #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_op,
    input  logic [15:0] req_data,
    input  logic        req_expect_rsp,
    output logic        per_start,
    output logic [23:0] per_in,
    input  logic        per_rdy,
    input  logic [23:0] per_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Counter value seen in the last permitted WAIT cycle.
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [7:0]        op_q, op_d;
    logic [15:0]       data_q, data_d;
    logic              expect_q, expect_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [15:0]       rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_err_q, rsp_err_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            data_q     <= '0;
            expect_q   <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            expect_q   <= expect_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // NOTE: every next-state signal is defaulted first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        expect_d   = expect_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    data_d     = req_data;
                    expect_d   = req_expect_rsp;
                    rsp_data_d = '0;
                    rsp_err_d  = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (!expect_q) begin
                    state_d = RESP;
                end else if (per_rdy) begin
                    rsp_data_d = per_out[15:0];
                    rsp_err_d  = {per_out[23:16] != op_q, 1'b0};
                    state_d    = RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A reply in the final permitted cycle beats the timeout.
                if (per_rdy) begin
                    rsp_data_d = per_out[15:0];
                    rsp_err_d  = {per_out[23:16] != op_q, 1'b0};
                    state_d    = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 2'b01;
                    state_d    = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The strobe is gated by rst so nothing leaves the block in a reset cycle.
    assign per_start = (state_q == ISSUE) && !rst;
    assign per_in    = per_start ? {op_q, data_q} : 24'h0;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_io_cmd_master.sv
// Directed bench for io_cmd_master: a default-timeout instance for the handshake and reply
// paths and an 8-cycle-timeout instance for the timeout boundary.
module tb_io_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_to;
    logic [7:0]  req_op;
    logic [15:0] req_data;
    logic        req_expect_rsp;
    logic        per_rdy;
    logic [23:0] per_out;
    logic        rsp_ready;

    logic        req_ready, per_start, rsp_valid, busy;
    logic [23:0] per_in;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_err;

    logic        req_ready_t, per_start_t, rsp_valid_t, busy_t;
    logic [23:0] per_in_t;
    logic [15:0] rsp_data_t;
    logic [1:0]  rsp_err_t;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    io_cmd_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_expect_rsp(req_expect_rsp),
        .per_start(per_start), .per_in(per_in), .per_rdy(per_rdy), .per_out(per_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    io_cmd_master #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut_to (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_to), .req_ready(req_ready_t),
        .req_op(req_op), .req_data(req_data), .req_expect_rsp(req_expect_rsp),
        .per_start(per_start_t), .per_in(per_in_t), .per_rdy(per_rdy), .per_out(per_out),
        .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready), .rsp_data(rsp_data_t),
        .rsp_err(rsp_err_t), .busy(busy_t)
    );

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic request(input logic [7:0] op, input logic [15:0] data, input logic exp);
        req_op         = op;
        req_data       = data;
        req_expect_rsp = exp;
        req_valid      = 1'b1;
        tick();
        req_valid      = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid_to = 1'b0;
        req_op = '0; req_data = '0; req_expect_rsp = 1'b0;
        per_rdy = 1'b0; per_out = '0; rsp_ready = 1'b0;
        ticks(2);

        chk("reset_req_ready", req_ready, 1);
        chk("reset_per_start", per_start, 0);
        chk("reset_per_in", per_in, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_busy", busy, 0);
        chk("reset_req_ready_to", req_ready_t, 1);
        rst = 1'b0;
        tick();

        // 1. Non-reply command.
        request(8'h01, 16'h0000, 1'b0);
        chk("t1_per_start", per_start, 1);
        chk("t1_per_in", per_in, 24'h010000);
        chk("t1_req_ready", req_ready, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_per_start_once", per_start, 0);
        chk("t1_per_in_idle", per_in, 0);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_data", rsp_data, 0);
        chk("t1_rsp_err", rsp_err, 0);
        handshake();
        chk("t1_busy_after", busy, 0);
        chk("t1_req_ready_after", req_ready, 1);
        chk("t1_rsp_valid_after", rsp_valid, 0);

        // 2. Reply in the same cycle as per_start.
        request(8'h04, 16'h0000, 1'b1);
        chk("t2_per_start", per_start, 1);
        per_rdy = 1'b1; per_out = 24'h041234;
        tick();
        per_rdy = 1'b0;
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_data", rsp_data, 16'h1234);
        chk("t2_rsp_err", rsp_err, 0);
        handshake();

        // 3a. Reply on WAIT cycle 10, matching opcode.
        request(8'h04, 16'h0000, 1'b1);
        tick();
        ticks(9);
        chk("t3a_waiting", rsp_valid, 0);
        chk("t3a_busy", busy, 1);
        per_rdy = 1'b1; per_out = 24'h04BEEF;
        tick();
        per_rdy = 1'b0;
        chk("t3a_rsp_valid", rsp_valid, 1);
        chk("t3a_rsp_data", rsp_data, 16'hBEEF);
        chk("t3a_rsp_err", rsp_err, 0);
        handshake();

        // 3b. Late reply with wrong opcode.
        request(8'h04, 16'h0000, 1'b1);
        ticks(3);
        per_rdy = 1'b1; per_out = 24'h05BEEF;
        tick();
        per_rdy = 1'b0;
        chk("t3b_rsp_valid", rsp_valid, 1);
        chk("t3b_rsp_data", rsp_data, 16'hBEEF);
        chk("t3b_rsp_err", rsp_err, 2'b10);
        handshake();

        // 4a. Timeout after exactly 8 WAIT cycles.
        req_op = 8'h04; req_data = 16'h0000; req_expect_rsp = 1'b1;
        req_valid_to = 1'b1;
        tick();
        req_valid_to = 1'b0;
        chk("t4_per_start", per_start_t, 1);
        tick();
        ticks(7);
        chk("t4_wait8_no_rsp", rsp_valid_t, 0);
        chk("t4_wait8_busy", busy_t, 1);
        tick();
        chk("t4_timeout_valid", rsp_valid_t, 1);
        chk("t4_timeout_err", rsp_err_t, 2'b01);
        chk("t4_timeout_data", rsp_data_t, 0);
        handshake();

        // 4b. Reply on the 8th WAIT cycle beats the timeout.
        req_valid_to = 1'b1;
        tick();
        req_valid_to = 1'b0;
        tick();
        ticks(7);
        per_rdy = 1'b1; per_out = 24'h04CAFE;
        tick();
        per_rdy = 1'b0;
        chk("t4b_rsp_valid", rsp_valid_t, 1);
        chk("t4b_rsp_err", rsp_err_t, 0);
        chk("t4b_rsp_data", rsp_data_t, 16'hCAFE);
        handshake();

        // 5. Backpressure with a second request pending.
        request(8'h10, 16'h0000, 1'b1);
        per_rdy = 1'b1; per_out = 24'h10ABCD;
        req_op = 8'h20; req_data = 16'h5555; req_expect_rsp = 1'b0;
        req_valid = 1'b1;
        tick();
        per_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", rsp_valid, 1);
            chk("t5_hold_data", rsp_data, 16'hABCD);
            chk("t5_hold_err", rsp_err, 0);
            chk("t5_hold_req_ready", req_ready, 0);
            chk("t5_hold_no_start", per_start, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t5_idle_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t5_second_start", per_start, 1);
        chk("t5_second_per_in", per_in, 24'h205555);
        tick();
        chk("t5_second_rsp", rsp_valid, 1);
        handshake();

        // 6. Reset in WAIT, then a stray late reply.
        request(8'h04, 16'h0000, 1'b1);
        ticks(2);
        chk("t6_in_wait", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_req_ready", req_ready, 1);
        chk("t6_busy", busy, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rsp_data", rsp_data, 0);
        chk("t6_rsp_err", rsp_err, 0);
        chk("t6_per_in", per_in, 0);
        per_rdy = 1'b1; per_out = 24'h04BEEF;
        tick();
        per_rdy = 1'b0;
        chk("t6_stray_no_rsp", rsp_valid, 0);
        chk("t6_stray_busy", busy, 0);

        // 6b. A start pulse that would fall in a reset cycle is suppressed.
        request(8'h33, 16'h7777, 1'b0);
        rst = 1'b1;
        #1;
        chk("t6b_start_suppressed", per_start, 0);
        chk("t6b_per_in_zero", per_in, 0);
        tick();
        rst = 1'b0;
        chk("t6b_idle", busy, 0);
        tick();
        chk("t6b_no_rsp", rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
